fim_rdack_mcfifo: RTL and testbench

- Multi-channel successor to the single-queue rdack FIFO: NUM_CH independent show-ahead queues, each 2**DEPTH_LOG2 deep.
- Queues are merged onto one rdack-style output through a round-robin arbiter.
- Sits between several producers (e.g. per-VF or per-port request streams) and one consumer that acknowledges data in the cycle it consumes it.
- Storage is self-contained registers; no scfifo instance.

---
 rtl/fim_rdack_mcfifo_if.sv | 37 +++
 rtl/fim_rdack_mcfifo.sv | 168 ++++++++++++++++
 tb/tb_fim_rdack_mcfifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fim_rdack_mcfifo_if.sv
// Bus bundle for fim_rdack_mcfifo: producer write port, per-channel status
// and the merged rdack-style read port.
interface fim_rdack_mcfifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DEPTH_LOG2 = 4
);
    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam int unsigned PW   = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0]  wdata_i;
    logic [CH_W-1:0]        wch_i;
    logic                   wreq_i;
    logic                   wdrop_o;
    logic [NUM_CH*PW-1:0]   usedw_o;
    logic [NUM_CH-1:0]      wfull_o;
    logic [NUM_CH-1:0]      almfull_o;
    logic [NUM_CH-1:0]      rempty_o;
    logic [DATA_WIDTH-1:0]  rdata_o;
    logic [CH_W-1:0]        rch_o;
    logic                   rvalid_o;
    logic                   rdack_i;

    // Producer/consumer side
    modport master (
        output wdata_i, wch_i, wreq_i, rdack_i,
        input  wdrop_o, usedw_o, wfull_o, almfull_o, rempty_o,
               rdata_o, rch_o, rvalid_o
    );

    // FIFO side
    modport slave (
        input  wdata_i, wch_i, wreq_i, rdack_i,
        output wdrop_o, usedw_o, wfull_o, almfull_o, rempty_o,
               rdata_o, rch_o, rvalid_o
    );
endinterface

// File: rtl/fim_rdack_mcfifo.sv
// Multi-channel show-ahead FIFO merged onto one rdack-style output.
// Define FIM_RDACK_MCFIFO_STRICT_PRIO_EN for fixed-priority arbitration (default: round-robin).
module fim_rdack_mcfifo #(
    parameter int unsigned DATA_WIDTH            = 32,
    parameter int unsigned NUM_CH                = 4,
    parameter int unsigned DEPTH_LOG2            = 4,
    parameter int unsigned ALMOST_FULL_THRESHOLD = 2**(DEPTH_LOG2-1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fim_rdack_mcfifo_if.slave    bus
);
    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned PW      = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH   = 2**DEPTH_LOG2;
    localparam bit          CH_POW2 = (NUM_CH == (1 << CH_W));

    logic [DATA_WIDTH-1:0] mem_q [NUM_CH][DEPTH];
    logic [PW-1:0]         wptr_q [NUM_CH];
    logic [PW-1:0]         wptr_d [NUM_CH];
    logic [PW-1:0]         rptr_q [NUM_CH];
    logic [PW-1:0]         rptr_d [NUM_CH];

    logic [NUM_CH-1:0]     wfull_q,   wfull_d;
    logic [NUM_CH-1:0]     almfull_q, almfull_d;
    logic [NUM_CH-1:0]     rempty_q,  rempty_d;
    logic [NUM_CH*PW-1:0]  usedw_q,   usedw_d;

    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic [CH_W-1:0]       rch_q,    rch_d;
    logic                  rvalid_q, rvalid_d;
    logic                  wdrop_q,  wdrop_d;

`ifndef FIM_RDACK_MCFIFO_STRICT_PRIO_EN
    logic [CH_W-1:0]       last_grant_q, last_grant_d;
`endif

    logic                  wch_ok_c;
    logic                  wr_en_c;
    logic                  load_c;
    logic [CH_W-1:0]       grant_c;
    logic [CH_W-1:0]       arb_idx_c;
    logic [PW-1:0]         used_c;

    // Out-of-range channel ids only exist when NUM_CH is not a power of two
    generate
        if (CH_POW2) begin : g_wch_all
            assign wch_ok_c = 1'b1;
        end else begin : g_wch_chk
            assign wch_ok_c = (32'(bus.wch_i) < NUM_CH);
        end
    endgenerate

    // Full is taken from registered state, so a same-cycle free does not admit a write
    assign wr_en_c = bus.wreq_i && wch_ok_c && !wfull_q[bus.wch_i];
    assign load_c  = (!rvalid_q || bus.rdack_i) && !(&rempty_q);

    // Arbiter: scan in reverse search order so the last hit is the first in priority
    always_comb begin
        grant_c   = '0;
        arb_idx_c = '0;
`ifdef FIM_RDACK_MCFIFO_STRICT_PRIO_EN
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            arb_idx_c = CH_W'(i);
            if (!rempty_q[arb_idx_c]) grant_c = arb_idx_c;
        end
`else
        for (int i = int'(NUM_CH); i > 0; i--) begin
            arb_idx_c = CH_W'((32'(last_grant_q) + 32'(i)) % NUM_CH);
            if (!rempty_q[arb_idx_c]) grant_c = arb_idx_c;
        end
`endif
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rdata_d   = rdata_q;
        rch_d     = rch_q;
        rvalid_d  = rvalid_q;
        wdrop_d   = bus.wreq_i && !wr_en_c;
        usedw_d   = '0;
        wfull_d   = '0;
        almfull_d = '0;
        rempty_d  = '0;
        used_c    = '0;
`ifndef FIM_RDACK_MCFIFO_STRICT_PRIO_EN
        last_grant_d = last_grant_q;
`endif

        if (wr_en_c) begin
            wptr_d[bus.wch_i] = wptr_q[bus.wch_i] + PW'(1);
        end

        if (load_c) begin
            rdata_d         = mem_q[grant_c][rptr_q[grant_c][DEPTH_LOG2-1:0]];
            rch_d           = grant_c;
            rvalid_d        = 1'b1;
            rptr_d[grant_c] = rptr_q[grant_c] + PW'(1);
`ifndef FIM_RDACK_MCFIFO_STRICT_PRIO_EN
            last_grant_d    = grant_c;
`endif
        end else if (bus.rdack_i && rvalid_q) begin
            rvalid_d = 1'b0;
        end

        // Status flags are registered from the next-state pointers
        for (int c = 0; c < int'(NUM_CH); c++) begin
            used_c                = wptr_d[c] - rptr_d[c];
            usedw_d[c*PW +: PW]   = used_c;
            rempty_d[c]           = (wptr_d[c] == rptr_d[c]);
            wfull_d[c]            = (wptr_d[c][DEPTH_LOG2] != rptr_d[c][DEPTH_LOG2]) &&
                                    (wptr_d[c][DEPTH_LOG2-1:0] == rptr_d[c][DEPTH_LOG2-1:0]);
            almfull_d[c]          = (used_c >= PW'(ALMOST_FULL_THRESHOLD));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
            end
            wfull_q   <= '0;
            almfull_q <= '0;
            rempty_q  <= '1;
            usedw_q   <= '0;
            rdata_q   <= '0;
            rch_q     <= '0;
            rvalid_q  <= 1'b0;
            wdrop_q   <= 1'b0;
`ifndef FIM_RDACK_MCFIFO_STRICT_PRIO_EN
            last_grant_q <= CH_W'(NUM_CH - 1);
`endif
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            wfull_q   <= wfull_d;
            almfull_q <= almfull_d;
            rempty_q  <= rempty_d;
            usedw_q   <= usedw_d;
            rdata_q   <= rdata_d;
            rch_q     <= rch_d;
            rvalid_q  <= rvalid_d;
            wdrop_q   <= wdrop_d;
`ifndef FIM_RDACK_MCFIFO_STRICT_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[bus.wch_i][wptr_q[bus.wch_i][DEPTH_LOG2-1:0]] <= bus.wdata_i;
        end
    end

    assign bus.wdrop_o   = wdrop_q;
    assign bus.usedw_o   = usedw_q;
    assign bus.wfull_o   = wfull_q;
    assign bus.almfull_o = almfull_q;
    assign bus.rempty_o  = rempty_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.rch_o     = rch_q;
    assign bus.rvalid_o  = rvalid_q;

endmodule

// File: tb/tb_fim_rdack_mcfifo.sv
// Directed self-checking bench for fim_rdack_mcfifo (NUM_CH=4, DEPTH_LOG2=4).
module tb_fim_rdack_mcfifo;
    localparam int unsigned DW = 32;
    localparam int unsigned NC = 4;
    localparam int unsigned DL = 4;
    localparam int unsigned PW = DL + 1;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_chk;

    fim_rdack_mcfifo_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH_LOG2(DL)) bus ();

    fim_rdack_mcfifo #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH_LOG2(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] uw(input int ch);
        return bus.usedw_o[ch*PW +: PW];
    endfunction

    task automatic wr(input int ch, input logic [DW-1:0] d);
        bus.wreq_i  = 1'b1;
        bus.wch_i   = 2'(ch);
        bus.wdata_i = d;
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        n_pass      = 0;
        n_chk       = 0;
        bus.wreq_i  = 1'b0;
        bus.wch_i   = '0;
        bus.wdata_i = '0;
        bus.rdack_i = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_rvalid",  64'(bus.rvalid_o),  64'h0);
        chk("rst_rempty",  64'(bus.rempty_o),  64'hF);
        chk("rst_wfull",   64'(bus.wfull_o),   64'h0);
        chk("rst_almfull", 64'(bus.almfull_o), 64'h0);
        chk("rst_usedw",   64'(bus.usedw_o),   64'h0);
        chk("rst_rdata",   64'(bus.rdata_o),   64'h0);
        chk("rst_rch",     64'(bus.rch_o),     64'h0);
        chk("rst_wdrop",   64'(bus.wdrop_o),   64'h0);
        rst_n = 1'b1;
        step();

        // Basic latency: write -> rempty low next cycle -> rvalid one later
        wr(2, 32'hA5);
        step();
        bus.wreq_i = 1'b0;
        chk("lat_rempty2", 64'(bus.rempty_o[2]), 64'h0);
        chk("lat_rvalid0", 64'(bus.rvalid_o),    64'h0);
        step();
        chk("lat_rvalid1", 64'(bus.rvalid_o), 64'h1);
        chk("lat_rdata",   64'(bus.rdata_o),  64'hA5);
        chk("lat_rch",     64'(bus.rch_o),    64'h2);
        chk("lat_usedw2",  64'(uw(2)),        64'h0);
        bus.rdack_i = 1'b1;
        step();
        bus.rdack_i = 1'b0;
        chk("lat_unload", 64'(bus.rvalid_o), 64'h0);

        // Fill ch1: first word moves to output, so 17 writes fill queue to 16
        for (int k = 1; k <= 17; k++) begin
            wr(1, 32'h100 + 32'(k - 1));
            step();
            chk($sformatf("fill_usedw_%0d", k), 64'(uw(1)), 64'((k == 1) ? 1 : k - 1));
            chk($sformatf("fill_alm_%0d", k), 64'(bus.almfull_o[1]), 64'(((k == 1) ? 1 : k - 1) >= 8));
            chk($sformatf("fill_full_%0d", k), 64'(bus.wfull_o[1]), 64'(k == 17));
        end
        wr(1, 32'hDEAD);
        step();
        bus.wreq_i = 1'b0;
        chk("drop_pulse", 64'(bus.wdrop_o),  64'h1);
        chk("drop_usedw", 64'(uw(1)),        64'd16);
        chk("drop_full",  64'(bus.wfull_o[1]), 64'h1);
        step();
        chk("drop_clear", 64'(bus.wdrop_o), 64'h0);

        // Drain in order; write in same cycle as freeing load is still dropped
        bus.rdack_i = 1'b1;
        wr(1, 32'hBEEF);
        for (int j = 0; j <= 16; j++) begin
            chk($sformatf("drain_rvalid_%0d", j), 64'(bus.rvalid_o), 64'h1);
            chk($sformatf("drain_rdata_%0d", j),  64'(bus.rdata_o),  64'h100 + 64'(j));
            chk($sformatf("drain_rch_%0d", j),    64'(bus.rch_o),    64'h1);
            step();
            if (j == 0) begin
                bus.wreq_i = 1'b0;
                chk("samecyc_drop", 64'(bus.wdrop_o), 64'h1);
            end
        end
        bus.rdack_i = 1'b0;
        chk("drain_done",   64'(bus.rvalid_o), 64'h0);
        chk("drain_rempty", 64'(bus.rempty_o), 64'hF);

        // Round-robin: 3 words per channel
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 3; i++) begin
                wr(c, 32'(c * 16 + i));
                step();
            end
        end
        bus.wreq_i = 1'b0;
        chk("rr_usedw", 64'(bus.usedw_o), 64'((3 << 15) | (3 << 10) | (3 << 5) | 2));
        bus.rdack_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("rr_rvalid_%0d", k), 64'(bus.rvalid_o), 64'h1);
            chk($sformatf("rr_rch_%0d", k),    64'(bus.rch_o),    64'(k % 4));
            chk($sformatf("rr_rdata_%0d", k),  64'(bus.rdata_o),  64'((k % 4) * 16 + k / 4));
            step();
        end
        bus.rdack_i = 1'b0;
        chk("rr_done", 64'(bus.rvalid_o), 64'h0);

        // Hold without ack
        wr(3, 32'h11);
        step();
        bus.wreq_i = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("hold_rvalid_%0d", k), 64'(bus.rvalid_o), 64'h1);
            chk($sformatf("hold_rdata_%0d", k),  64'(bus.rdata_o),  64'h11);
            chk($sformatf("hold_rch_%0d", k),    64'(bus.rch_o),    64'h3);
            chk($sformatf("hold_usedw_%0d", k),  64'(uw(3)),        64'h0);
            step();
        end
        bus.rdack_i = 1'b1;
        step();
        bus.rdack_i = 1'b0;
        chk("hold_release", 64'(bus.rvalid_o), 64'h0);

        // Simultaneous write and load on ch0
        wr(0, 32'h21);
        step();
        wr(0, 32'h22);
        step();
        bus.wreq_i = 1'b0;
        chk("sim_rdata0", 64'(bus.rdata_o), 64'h21);
        chk("sim_used0",  64'(uw(0)),       64'h1);
        wr(0, 32'h23);
        bus.rdack_i = 1'b1;
        step();
        bus.wreq_i = 1'b0;
        chk("sim_rdata1", 64'(bus.rdata_o), 64'h22);
        chk("sim_used1",  64'(uw(0)),       64'h1);
        step();
        chk("sim_rdata2", 64'(bus.rdata_o), 64'h23);
        chk("sim_used2",  64'(uw(0)),       64'h0);
        step();
        bus.rdack_i = 1'b0;
        chk("sim_done", 64'(bus.rvalid_o), 64'h0);

        // Async reset while output is valid
        wr(1, 32'h31);
        step();
        wr(2, 32'h32);
        step();
        bus.wreq_i = 1'b0;
        step();
        chk("ar_pre_rvalid", 64'(bus.rvalid_o), 64'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_rvalid", 64'(bus.rvalid_o), 64'h0);
        chk("ar_rempty", 64'(bus.rempty_o), 64'hF);
        chk("ar_usedw",  64'(bus.usedw_o),  64'h0);
        chk("ar_rdata",  64'(bus.rdata_o),  64'h0);
        step();
        rst_n = 1'b1;
        wr(3, 32'h33);
        step();
        wr(0, 32'h34);
        step();
        bus.wreq_i = 1'b0;
        chk("ar_first_rch",   64'(bus.rch_o),   64'h3);
        chk("ar_first_rdata", 64'(bus.rdata_o), 64'h33);
        bus.rdack_i = 1'b1;
        step();
        chk("ar_next_rch",   64'(bus.rch_o),   64'h0);
        chk("ar_next_rdata", 64'(bus.rdata_o), 64'h34);
        step();
        bus.rdack_i = 1'b0;
        chk("ar_done", 64'(bus.rvalid_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
